// File: rtl/wport_rr_arbiter.sv
// Round-robin owner selection for the shared register-file write port.
// Registered index/enable drive the write-select decoder; gnt is the one-hot acknowledge copy.
module wport_rr_arbiter #(
  parameter int MAX_BURST  = 4,
  parameter int GAP_CYCLES = 1
) (
  input  logic       clk,
  input  logic       rstn,
  input  logic [7:0] req,
  input  logic [7:0] last,
  output logic [2:0] gnt_idx,
  output logic       gnt_en,
  output logic [7:0] gnt,
  output logic       busy
);

  typedef enum logic [1:0] {IDLE, GRANT, GAP} state_t;

  localparam logic [3:0] LAST_BEAT = 4'(MAX_BURST - 1);
  localparam logic [1:0] LAST_GAP  = 2'(GAP_CYCLES - 1);

  state_t     state_q, state_d;
  logic [2:0] ptr_q, ptr_d;
  logic [3:0] beat_cnt_q, beat_cnt_d;
  logic [1:0] gap_cnt_q, gap_cnt_d;
  logic [2:0] idx_d;
  logic       en_d;
  logic       beat;
  logic       rel;
  logic [3:0] pick_idle;
  logic [3:0] pick_next;

  // Returns {found, index} of the first set bit scanning start, start+1, ... mod 8.
  function automatic logic [3:0] rr_pick(input logic [7:0] r, input logic [2:0] start);
    logic [3:0] res;
    logic [2:0] k;
    res = '0;
    for (int i = 7; i >= 0; i--) begin
      k = start + 3'(i);
      if (r[k]) res = {1'b1, k};
    end
    return res;
  endfunction

  assign beat      = gnt_en & req[gnt_idx];
  assign rel       = ~req[gnt_idx] | (beat & last[gnt_idx]) | (beat & (beat_cnt_q == LAST_BEAT));
  assign pick_idle = rr_pick(req, ptr_q);
  // Back-to-back handover never returns the port to the requester that just released it.
  assign pick_next = rr_pick(req & ~(8'b1 << gnt_idx), gnt_idx + 3'd1);

  always_comb begin
    state_d    = state_q;
    ptr_d      = ptr_q;
    beat_cnt_d = beat_cnt_q;
    gap_cnt_d  = gap_cnt_q;
    idx_d      = gnt_idx;
    en_d       = gnt_en;
    case (state_q)
      IDLE: begin
        if (pick_idle[3]) begin
          idx_d      = pick_idle[2:0];
          en_d       = 1'b1;
          state_d    = GRANT;
          beat_cnt_d = '0;
        end
      end
      GRANT: begin
        if (!rel) begin
          if (beat) beat_cnt_d = beat_cnt_q + 4'd1;
        end else begin
          ptr_d      = gnt_idx + 3'd1;
          beat_cnt_d = '0;
          if (GAP_CYCLES != 0) begin
            en_d      = 1'b0;
            state_d   = GAP;
            gap_cnt_d = '0;
          end else if (pick_next[3]) begin
            idx_d = pick_next[2:0];
          end else begin
            en_d    = 1'b0;
            state_d = IDLE;
          end
        end
      end
      GAP: begin
        en_d      = 1'b0;
        gap_cnt_d = gap_cnt_q + 2'd1;
        if (gap_cnt_q == LAST_GAP) state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
        en_d    = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      state_q    <= IDLE;
      ptr_q      <= '0;
      beat_cnt_q <= '0;
      gap_cnt_q  <= '0;
      gnt_idx    <= '0;
      gnt_en     <= 1'b0;
      gnt        <= '0;
      busy       <= 1'b0;
    end else begin
      state_q    <= state_d;
      ptr_q      <= ptr_d;
      beat_cnt_q <= beat_cnt_d;
      gap_cnt_q  <= gap_cnt_d;
      gnt_idx    <= idx_d;
      gnt_en     <= en_d;
      gnt        <= en_d ? (8'b1 << idx_d) : 8'b0;
      busy       <= (state_d != IDLE);
    end
  end

endmodule

// File: tb/tb_wport_rr_arbiter.sv
// Directed bench for wport_rr_arbiter: default instance (burst 4, gap 1) and a
// single-beat, zero-gap instance; grant order is scoreboarded, timing checked inline.
module tb_wport_rr_arbiter;

  logic       clk = 1'b0;
  logic       rstn;
  logic [7:0] req_a, last_a, req_b, last_b;
  logic [2:0] gnt_idx_a, gnt_idx_b;
  logic       gnt_en_a, gnt_en_b, busy_a, busy_b;
  logic [7:0] gnt_a, gnt_b;

  int vectors = 0;
  int miscompares = 0;
  logic mon_on = 1'b0;
  logic [2:0] exp_a[$];
  logic [2:0] exp_b[$];
  logic [7:0] req_prev_a = '0;
  logic [7:0] req_prev_b = '0;
  logic [2:0] ea, eb;

  always #5 clk = ~clk;

  wport_rr_arbiter dut_a (
    .clk(clk), .rstn(rstn), .req(req_a), .last(last_a),
    .gnt_idx(gnt_idx_a), .gnt_en(gnt_en_a), .gnt(gnt_a), .busy(busy_a)
  );

  wport_rr_arbiter #(.MAX_BURST(1), .GAP_CYCLES(0)) dut_b (
    .clk(clk), .rstn(rstn), .req(req_b), .last(last_b),
    .gnt_idx(gnt_idx_b), .gnt_en(gnt_en_b), .gnt(gnt_b), .busy(busy_b)
  );

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic chk(input string name, input int act, input int exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Scoreboard monitors: one pop per granted cycle, plus one-hot and request checks.
  always @(negedge clk) begin
    if (mon_on) begin
      chk("onehot_a", int'($countones(gnt_a) <= 1), 1);
      if (gnt_en_a === 1'b1) begin
        chk("req_held_a", int'(req_prev_a[gnt_idx_a]), 1);
        if (exp_a.size() == 0) begin
          vectors++;
          miscompares++;
          $display("FAIL grant_a: unexpected grant to %0d, none expected", gnt_idx_a);
        end else begin
          ea = exp_a.pop_front();
          chk("sb_idx_a", int'(gnt_idx_a), int'(ea));
          chk("sb_gnt_a", int'(gnt_a), int'(8'b1 << ea));
        end
      end else begin
        chk("gnt_idle_a", int'(gnt_a), 0);
      end
      req_prev_a = req_a;
    end
  end

  always @(negedge clk) begin
    if (mon_on) begin
      chk("onehot_b", int'($countones(gnt_b) <= 1), 1);
      if (gnt_en_b === 1'b1) begin
        chk("req_held_b", int'(req_prev_b[gnt_idx_b]), 1);
        if (exp_b.size() == 0) begin
          vectors++;
          miscompares++;
          $display("FAIL grant_b: unexpected grant to %0d, none expected", gnt_idx_b);
        end else begin
          eb = exp_b.pop_front();
          chk("sb_idx_b", int'(gnt_idx_b), int'(eb));
          chk("sb_gnt_b", int'(gnt_b), int'(8'b1 << eb));
        end
      end else begin
        chk("gnt_idle_b", int'(gnt_b), 0);
      end
      req_prev_b = req_b;
    end
  end

  initial begin
    #50000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rstn = 1'b0; req_a = '0; last_a = '0; req_b = '0; last_b = '0;
    step();
    step();
    chk("rst_en_a", int'(gnt_en_a), 0);
    chk("rst_gnt_a", int'(gnt_a), 0);
    chk("rst_idx_a", int'(gnt_idx_a), 0);
    chk("rst_busy_a", int'(busy_a), 0);
    chk("rst_en_b", int'(gnt_en_b), 0);
    mon_on = 1'b1;

    // Single requester, full bursts; last of non-owners must be ignored.
    rstn = 1'b1; req_a = 8'h01; last_a = 8'hFE;
    for (int i = 0; i < 5; i++) exp_a.push_back(3'd0);
    step();
    chk("first_en", int'(gnt_en_a), 1);
    chk("first_idx", int'(gnt_idx_a), 0);
    chk("first_gnt", int'(gnt_a), 8'h01);
    chk("first_busy", int'(busy_a), 1);
    step(); step(); step();
    chk("beat4_en", int'(gnt_en_a), 1);
    step();
    chk("gap_en", int'(gnt_en_a), 0);
    chk("gap_busy", int'(busy_a), 1);
    step();
    chk("idle_en", int'(gnt_en_a), 0);
    chk("idle_busy", int'(busy_a), 0);
    step();
    chk("regrant_en", int'(gnt_en_a), 1);
    chk("regrant_idx", int'(gnt_idx_a), 0);
    req_a = 8'h00; last_a = 8'h00;
    step();
    chk("drop0_en", int'(gnt_en_a), 0);
    step();

    // Park ptr at 3 by granting and releasing requester 2.
    req_a = 8'h04;
    exp_a.push_back(3'd2);
    step();
    chk("park2_idx", int'(gnt_idx_a), 2);
    req_a = 8'h00;
    step(); step();

    // req=84 from ptr=3: 7 first, released by last on 2nd beat, then 2.
    req_a = 8'h84;
    exp_a.push_back(3'd7); exp_a.push_back(3'd7);
    for (int i = 0; i < 4; i++) exp_a.push_back(3'd2);
    exp_a.push_back(3'd7);
    step();
    chk("r84_first_idx", int'(gnt_idx_a), 7);
    step();
    last_a = 8'h80;
    step();
    chk("last_release_en", int'(gnt_en_a), 0);
    last_a = 8'h00;
    step();
    step();
    chk("r84_second_idx", int'(gnt_idx_a), 2);
    chk("r84_second_en", int'(gnt_en_a), 1);
    step(); step(); step();
    chk("r2_beat4_en", int'(gnt_en_a), 1);
    step();
    chk("r2_release_en", int'(gnt_en_a), 0);
    step();
    chk("r2_idle_busy", int'(busy_a), 0);
    step();
    chk("ptr_after_2", int'(gnt_idx_a), 7);
    req_a = 8'h00;
    step(); step();

    // Owner 5 drops req after 2 beats; next winner from ptr=6 must be 0.
    req_a = 8'h20;
    for (int i = 0; i < 3; i++) exp_a.push_back(3'd5);
    exp_a.push_back(3'd0);
    step();
    chk("own5_idx", int'(gnt_idx_a), 5);
    step(); step();
    req_a = 8'h00;
    step();
    chk("drop_release_en", int'(gnt_en_a), 0);
    req_a = 8'h21;
    step();
    chk("drop_gap_en", int'(gnt_en_a), 0);
    step();
    chk("ptr_after_5", int'(gnt_idx_a), 0);
    req_a = 8'h00;
    step(); step();

    // Reset while requester 3 owns the port; ptr must restart at 0.
    req_a = 8'h08;
    exp_a.push_back(3'd3); exp_a.push_back(3'd0);
    step();
    chk("own3_idx", int'(gnt_idx_a), 3);
    rstn = 1'b0;
    step();
    chk("midrst_en", int'(gnt_en_a), 0);
    chk("midrst_gnt", int'(gnt_a), 0);
    chk("midrst_idx", int'(gnt_idx_a), 0);
    chk("midrst_busy", int'(busy_a), 0);
    rstn = 1'b1; req_a = 8'h81;
    step();
    chk("ptr_reset_idx", int'(gnt_idx_a), 0);
    req_a = 8'h00;
    step(); step();

    // Single-beat, zero-gap instance: back-to-back rotation through all requesters.
    req_b = 8'hFF;
    for (int k = 0; k < 10; k++) exp_b.push_back(3'(k % 8));
    for (int k = 0; k < 10; k++) begin
      step();
      chk("b2b_en", int'(gnt_en_b), 1);
      chk("b2b_idx", int'(gnt_idx_b), k % 8);
    end
    req_b = 8'h00;
    step();
    chk("b_release_en", int'(gnt_en_b), 0);
    chk("b_release_busy", int'(busy_b), 0);

    // Sole requester is re-granted only after a one-cycle IDLE.
    req_b = 8'h04;
    exp_b.push_back(3'd2); exp_b.push_back(3'd2);
    step();
    chk("solo_en", int'(gnt_en_b), 1);
    chk("solo_idx", int'(gnt_idx_b), 2);
    step();
    chk("solo_idle_en", int'(gnt_en_b), 0);
    step();
    chk("solo_regrant_en", int'(gnt_en_b), 1);
    req_b = 8'h00;
    step(); step();

    chk("queue_a_drained", exp_a.size(), 0);
    chk("queue_b_drained", exp_b.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
